vga_frame_sync_ctrl: RTL

Register-update controller that sits between the Avalon-MM slave port and the sprite/score renderer of the VGA display. CPU writes land in a shadow register bank. They are copied into the active bank, which drives the renderer, only at the start of vertical blank after an explicit commit. This prevents tearing when sprite positions change mid-frame. The block also owns the frame counter and the walk/flap animation phase sequencer that the renderer uses for sprite selection.

---
 rtl/vga_frame_sync_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vga_frame_sync_ctrl.sv
// Shadow/active sprite register bank with vblank-synchronised commit, frame counter and animation phase.
// Optional vblank interrupt enabled by defining VGA_FRAME_SYNC_IRQ_EN.
module vga_frame_sync_ctrl #(
   parameter int NREGS       = 16,
   parameter int VACTIVE     = 480,
   parameter int ANIM_FRAMES = 6,
   parameter int ANIM_PHASES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  chipselect,
   input  logic                  write,
   input  logic                  read,
   input  logic [8:0]            address,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [10:0]           hcount,
   input  logic [9:0]            vcount,
   output logic [NREGS*16-1:0]   active_regs,
   output logic [1:0]            anim_phase,
   output logic [15:0]           frame_count,
   output logic                  commit_pulse,
   output logic                  irq
);

   localparam int         AW          = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [8:0] ADDR_COMMIT = 9'h100;
   localparam logic [8:0] ADDR_STATUS = 9'h101;
   localparam logic [15:0] DIV_LAST   = 16'(ANIM_FRAMES - 1);
   localparam logic [1:0]  PHASE_LAST = 2'(ANIM_PHASES - 1);

   logic [15:0]   shadow [NREGS];
   logic [15:0]   active [NREGS];
   logic          pending;
   logic          vb_cond;
   logic          vb_cond_q;
   logic          vblank_start;
   logic [15:0]   anim_div;
   logic          wr_en;
   logic          rd_en;
   logic          reg_hit;
   logic [AW-1:0] reg_idx;
   logic [31:0]   rd_value;
   logic          unused_wdata;

   assign wr_en        = chipselect && write;
   assign rd_en        = chipselect && read;
   assign reg_hit      = ({1'b0, address} < 10'(NREGS));
   assign reg_idx      = address[AW-1:0];
   assign unused_wdata = &{1'b0, writedata[31:16]};

   // hcount may sit at 0 for several cycles; only the first cycle of the condition counts
   assign vb_cond      = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
   assign vblank_start = vb_cond && !vb_cond_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) vb_cond_q <= 1'b0;
      else       vb_cond_q <= vb_cond;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
      end else if (wr_en && reg_hit) begin
         shadow[reg_idx] <= writedata[15:0];
      end
   end

   // The copy samples shadow before any same-cycle CPU write lands
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) active[i] <= '0;
         commit_pulse <= 1'b0;
      end else begin
         commit_pulse <= vblank_start && pending;
         if (vblank_start && pending) begin
            for (int i = 0; i < NREGS; i++) active[i] <= shadow[i];
         end
      end
   end

   // A COMMIT arriving on the vblank cycle survives to the next frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    pending <= 1'b0;
      else if (wr_en && (address == ADDR_COMMIT))   pending <= 1'b1;
      else if (vblank_start)                        pending <= 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_count <= '0;
         anim_div    <= '0;
         anim_phase  <= '0;
      end else if (vblank_start) begin
         frame_count <= frame_count + 16'd1;
         if (anim_div == DIV_LAST) begin
            anim_div   <= '0;
            anim_phase <= (anim_phase == PHASE_LAST) ? 2'd0 : anim_phase + 2'd1;
         end else begin
            anim_div <= anim_div + 16'd1;
         end
      end
   end

`ifdef VGA_FRAME_SYNC_IRQ_EN
   localparam logic [8:0] ADDR_IRQ_ACK = 9'h102;
   logic ack_en;
   assign ack_en = wr_en && (address == ADDR_IRQ_ACK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)             irq <= 1'b0;
      else if (vblank_start) irq <= 1'b1;
      else if (ack_en)       irq <= 1'b0;
   end
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_value = '0;
      if (reg_hit)                         rd_value = {16'h0, shadow[reg_idx]};
      else if (address == ADDR_STATUS)     rd_value = {14'h0, irq, pending, frame_count};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      readdata <= '0;
      else if (rd_en) readdata <= rd_value;
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_active
      assign active_regs[16*g +: 16] = active[g];
   end

endmodule
